// File: rtl/io_responder_pkg.sv
// io_pkg: I/O port map, status bit positions and FIFO state encoding.
// Rev 1.0
`default_nettype none

package io_pkg;

  localparam logic [7:0] ID_SW    = 8'h20;
  localparam logic [7:0] ID_FDATA = 8'h30;
  localparam logic [7:0] ID_FSTAT = 8'h31;
  localparam logic [7:0] ID_LED   = 8'h40;
  localparam logic [7:0] ID_SSEG  = 8'h81;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_UNDF  = 2;

  typedef logic [1:0] fifo_state_t;
  localparam fifo_state_t FS_EMPTY   = 2'd0;
  localparam fifo_state_t FS_PARTIAL = 2'd1;
  localparam fifo_state_t FS_FULL    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/io_responder_if.sv
// io_responder_if: MCU I/O bus plus board-side signals of the I/O responder.
// Rev 1.0
`default_nettype none

interface io_responder_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic       io_rd;
  logic [7:0] in_port;
  logic [7:0] switches;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic [7:0] leds;
  logic [7:0] sseg;
  logic       int_req;

  modport slave (
    input  port_id, out_port, io_strb, io_rd, switches, ext_data, ext_valid,
    output in_port, ext_ready, leds, sseg, int_req
  );

  modport master (
    output port_id, out_port, io_strb, io_rd, switches, ext_data, ext_valid,
    input  in_port, ext_ready, leds, sseg, int_req
  );
endinterface

`default_nettype wire

// File: rtl/io_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with EMPTY/PARTIAL/FULL state tracked alongside the count.
// Rev 1.0
`default_nettype none

module sync_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_count_nxt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  fifo_state_t      r_state;
  fifo_state_t      w_state_nxt;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CW-1:0]    w_count_nxt;

  assign w_push_ok   = i_push & (r_state != FS_FULL);
  assign w_pop_ok    = i_pop  & (r_state != FS_EMPTY);
  assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= FS_EMPTY;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Storage is not reset: contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_comb begin
    w_state_nxt = FS_PARTIAL;
    if (w_count_nxt == '0)
      w_state_nxt = FS_EMPTY;
    else if (w_count_nxt == CW'(DEPTH))
      w_state_nxt = FS_FULL;
  end

  always_comb begin
    o_full  = (r_state == FS_FULL);
    o_empty = (r_state == FS_EMPTY);
  end

  assign o_head      = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;

endmodule

`default_nettype wire

// File: rtl/io_responder.sv
// io_responder: MCU-side I/O peripheral with LED/7-seg registers, switch input and a byte FIFO.
// Rev 1.0
`default_nettype none

module io_responder
  import io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  io_responder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    r_leds;
  logic [7:0]    r_sseg;
  logic [7:0]    r_sw_meta;
  logic [7:0]    r_sw_sync;
  logic          r_underflow;
  logic          r_int_req;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic [7:0]    w_count8;
  logic          w_push;
  logic          w_pop_req;
  logic          w_ready;
  logic [7:0]    w_status;
  logic [7:0]    w_in_port;

  assign w_ready   = (w_count != CW'(DEPTH));
  assign w_push    = bus.ext_valid & w_ready;
  assign w_pop_req = bus.io_rd & (bus.port_id == ID_FDATA);
  assign w_count8  = 8'(w_count);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      (bus.ext_data),
    .i_pop       (w_pop_req),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_leds      <= '0;
      r_sseg      <= '0;
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
      r_underflow <= 1'b0;
      r_int_req   <= 1'b0;
    end else begin
      r_sw_meta <= bus.switches;
      r_sw_sync <= r_sw_meta;
      r_int_req <= (w_count_nxt != '0);
      if (bus.io_strb && bus.port_id == ID_LED)  r_leds <= bus.out_port;
      if (bus.io_strb && bus.port_id == ID_SSEG) r_sseg <= bus.out_port;
      // A fresh underflow wins over a coincident write-1-to-clear.
      if (w_pop_req && w_empty)
        r_underflow <= 1'b1;
      else if (bus.io_strb && bus.port_id == ID_FSTAT && bus.out_port[STAT_UNDF])
        r_underflow <= 1'b0;
    end
  end

  always_comb begin
    w_status             = {w_count8[3:0], 4'b0000};
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_UNDF]  = r_underflow;
  end

  always_comb begin
    w_in_port = 8'h00;
    case (bus.port_id)
      ID_SW:    w_in_port = r_sw_sync;
      ID_FDATA: w_in_port = w_empty ? 8'h00 : w_head;
      ID_FSTAT: w_in_port = w_status;
      default:  w_in_port = 8'h00;
    endcase
  end

  assign bus.in_port   = w_in_port;
  assign bus.ext_ready = w_ready;
  assign bus.leds      = r_leds;
  assign bus.sseg      = r_sseg;
  assign bus.int_req   = r_int_req;

endmodule

`default_nettype wire

// File: tb/tb_io_responder.sv
// tb_io_responder: directed and random stimulus against a queue-based model of the I/O responder.
// Rev 1.0
`default_nettype none

module tb_io_responder;

  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  io_responder_if bus();

  io_responder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [7:0] q[$];
  logic       m_undf;
  logic [7:0] m_leds;
  logic [7:0] m_sseg;
  logic [7:0] m_sw1;
  logic [7:0] m_sw2;
  logic       m_int;

  function automatic logic [7:0] m_status();
    int n;
    n = q.size();
    return {n[3:0], 1'b0, m_undf, (n == DEPTH), (n == 0)};
  endfunction

  function automatic logic [7:0] m_in(input logic [7:0] pid);
    if (pid == 8'h20) return m_sw2;
    if (pid == 8'h30) return (q.size() != 0) ? q[0] : 8'h00;
    if (pid == 8'h31) return m_status();
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit strb, input bit rd, input logic [7:0] pid,
                       input logic [7:0] od, input bit ev, input logic [7:0] ed);
    bit push_ok;
    bus.io_strb   = strb;
    bus.io_rd     = rd;
    bus.port_id   = pid;
    bus.out_port  = od;
    bus.ext_valid = ev;
    bus.ext_data  = ed;
    #1;
    chk("in_port", bus.in_port, m_in(pid));
    chk("ext_ready", 8'(bus.ext_ready), 8'(q.size() != DEPTH));
    push_ok = ev && (q.size() < DEPTH);
    if (rd && pid == 8'h30) begin
      if (q.size() != 0) void'(q.pop_front());
      else m_undf = 1'b1;
    end
    if (strb) begin
      if (pid == 8'h40) m_leds = od;
      if (pid == 8'h81) m_sseg = od;
      if (pid == 8'h31 && od[2]) m_undf = 1'b0;
    end
    if (push_ok) q.push_back(ed);
    m_sw2 = m_sw1;
    m_sw1 = bus.switches;
    m_int = (q.size() != 0);
    @(posedge clk);
    #1;
    chk("leds", bus.leds, m_leds);
    chk("sseg", bus.sseg, m_sseg);
    chk("int_req", 8'(bus.int_req), 8'(m_int));
    bus.io_strb   = 1'b0;
    bus.io_rd     = 1'b0;
    bus.ext_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.io_strb   = 1'b0;
    bus.io_rd     = 1'b0;
    bus.ext_valid = 1'b0;
    bus.port_id   = 8'h31;
    rst = 1'b1;
    q.delete();
    m_undf = 1'b0; m_leds = 8'h00; m_sseg = 8'h00;
    m_sw1 = 8'h00; m_sw2 = 8'h00; m_int = 1'b0;
    #1;
    chk("rst_leds", bus.leds, 8'h00);
    chk("rst_sseg", bus.sseg, 8'h00);
    chk("rst_int", 8'(bus.int_req), 8'h00);
    chk("rst_status", bus.in_port, 8'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", 8'(bus.ext_ready), 8'h01);
  endtask

  task automatic read_port(input logic [7:0] pid);
    cycle(1'b0, 1'b0, pid, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic pop_fifo();
    cycle(1'b0, 1'b1, 8'h30, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] d);
    cycle(1'b0, 1'b0, 8'h31, 8'h00, 1'b1, d);
  endtask

  initial begin
    logic [7:0] ids [6];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.switches = 8'h00;
    bus.out_port = 8'h00;
    bus.ext_data = 8'h00;
    ids[0] = 8'h20; ids[1] = 8'h30; ids[2] = 8'h31;
    ids[3] = 8'h40; ids[4] = 8'h81; ids[5] = 8'h55;
    #1;
    do_reset();

    // Reset in the middle of activity
    cycle(1'b1, 1'b0, 8'h40, 8'h77, 1'b0, 8'h00);
    push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3);
    do_reset();

    // Output registers and switch synchroniser
    bus.switches = 8'h5A;
    cycle(1'b1, 1'b0, 8'h40, 8'hA5, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h81, 8'h3C, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h55, 8'hFF, 1'b0, 8'h00);
    read_port(8'h20);
    read_port(8'h20);
    chk("leds_a5", bus.leds, 8'hA5);
    chk("sseg_3c", bus.sseg, 8'h3C);

    // Basic push / pop order
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    pop_fifo(); pop_fifo(); pop_fifo();
    read_port(8'h31);

    // Fill, back-pressure, held valid accepted after one pop
    for (int i = 0; i < DEPTH; i++) push_byte(8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) push_byte(8'h99);
    chk("full_status", bus.in_port, 8'h82);
    cycle(1'b0, 1'b1, 8'h30, 8'h00, 1'b1, 8'h99);
    push_byte(8'h99);
    read_port(8'h31);
    for (int i = 0; i < DEPTH; i++) pop_fifo();

    // Underflow and write-1-to-clear
    pop_fifo();
    read_port(8'h31);
    cycle(1'b1, 1'b0, 8'h31, 8'h04, 1'b0, 8'h00);
    read_port(8'h31);

    // Simultaneous push and pop at count 4
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    cycle(1'b0, 1'b1, 8'h30, 8'h00, 1'b1, 8'hB5);
    read_port(8'h31);
    read_port(8'h30);

    // Random traffic
    for (int i = 0; i < 20; i++) begin
      int kind;
      logic [7:0] pid;
      kind = int'($urandom_range(0, 2));
      pid  = ids[$urandom_range(0, 5)];
      if (kind == 2 && $urandom_range(0, 3) != 0) pid = 8'h30;
      bus.switches = 8'($urandom);
      cycle(kind == 1, kind == 2, pid, 8'($urandom), 1'($urandom), 8'($urandom));
    end
    read_port(8'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
